// File: rtl/frame_buf_writer_if.sv
// Pixel stream input and Avalon-MM write port of the frame buffer writer.
// The writer uses the master modport; the pixel source and memory side use slave.
interface frame_buf_writer_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              in_sof;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;

    modport master (
        input  in_valid, in_data, in_sof, waitrequest,
        output in_ready, address, byteenable, chipselect, write, writedata
    );

    modport slave (
        output in_valid, in_data, in_sof, waitrequest,
        input  in_ready, address, byteenable, chipselect, write, writedata
    );
endinterface

// File: rtl/frame_buf_writer.sv
// Packs RGB565 pixel pairs into 32-bit words and writes one frame into the
// on-chip frame buffer, with SOF alignment, single/continuous capture and stalls.
//
// state | meaning
// IDLE  | waiting for an SOF pixel while armed; all other pixels dropped
// LO    | next accepted pixel is the low half of a word
// HI    | next accepted pixel completes a word and queues the write
module frame_buf_writer #(
    parameter int NUM_WORDS = 38400,
    parameter int ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    frame_buf_writer_if.master   bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t              state;
    state_t              state_next;

    logic                armed;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [15:0]         lo_pix;
    logic                write_r;
    logic [ADDR_W-1:0]   address_r;
    logic [31:0]         writedata_r;
    logic                frame_done_r;
    logic                err_r;

    logic                in_ready_int;
    logic                accept;
    logic                retire;
    logic                last_retire;
    logic                capture;
    logic                restart;
    logic                load;
    logic                sof_mid;

    // IDLE never loads a word, so it can always take (and mostly drop) pixels.
    assign in_ready_int = ~reset & ((state == IDLE) | ~(write_r & bus.waitrequest));
    assign accept       = bus.in_valid & in_ready_int;
    assign retire       = write_r & ~bus.waitrequest;
    assign last_retire  = retire & (address_r == LAST_ADDR);

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        restart    = 1'b0;
        load       = 1'b0;
        sof_mid    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && bus.in_sof && armed) begin
                    capture    = 1'b1;
                    restart    = 1'b1;
                    state_next = HI;
                end
            end
            LO: begin
                if (accept) begin
                    capture    = 1'b1;
                    state_next = HI;
                    if (bus.in_sof) begin
                        restart = 1'b1;
                        sof_mid = 1'b1;
                    end
                end
            end
            HI: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        // Realign: the held lo pixel is dropped, SOF pixel starts word 0.
                        capture = 1'b1;
                        restart = 1'b1;
                        sof_mid = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = (addr_cnt == LAST_ADDR) ? IDLE : LO;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed        <= 1'b0;
            addr_cnt     <= '0;
            lo_pix       <= '0;
            write_r      <= 1'b0;
            address_r    <= '0;
            writedata_r  <= '0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            if (capture) lo_pix <= bus.in_data;

            if (restart)
                addr_cnt <= '0;
            else if (load && (addr_cnt != LAST_ADDR))
                addr_cnt <= addr_cnt + ADDR_W'(1);

            // A new word may replace one retiring in the same cycle.
            if (load) begin
                write_r     <= 1'b1;
                address_r   <= addr_cnt;
                writedata_r <= {bus.in_data, lo_pix};
            end else if (retire) begin
                write_r <= 1'b0;
            end

            frame_done_r <= last_retire;

            if (sof_mid)    err_r <= 1'b1;
            else if (start) err_r <= 1'b0;

            if (start || (continuous && (state == IDLE)))
                armed <= 1'b1;
            else if (last_retire && !continuous)
                armed <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.address    = address_r;
    assign bus.byteenable = 4'b1111;
    assign bus.chipselect = write_r;
    assign bus.write      = write_r;
    assign bus.writedata  = writedata_r;

    assign busy       = armed | (state != IDLE) | write_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

endmodule
